keccak_msg_feeder: RTL and testbench
====================================

# keccak_msg_feeder

Host-side front end for the `keccak` core. It accepts a byte-serial message, packs bytes big-endian into 32-bit words, and drives the core's `in`/`in_ready`/`is_last`/`byte_num` input while honouring `buffer_full`. When the core raises `out_ready`, it captures the 512-bit digest, streams it out as sixteen 32-bit words, then pulses a core reset so the next message starts clean.

## Interface
- No parameters.
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- s_data  in  8  message byte
- s_valid  in  1  byte valid
- s_last  in  1  byte is final byte of message; minimum message is 1 byte
- s_ready  out  1  byte accepted when s_valid & s_ready
- k_in  out  32  word to core; first byte in [31:24]
- k_in_ready  out  1  word transfer strobe to core
- k_is_last  out  1  final-transfer marker; only ever high together with k_in_ready
- k_byte_num  out  2  valid bytes in k_in when k_is_last (0..3)
- k_buffer_full  in  1  core padder full; no transfer may be issued while high
- k_out  in  512  core digest
- k_out_ready  in  1  core digest valid (sticky until core reset)
- k_reset  out  1  core reset = reset | (state==CORE_RST)
- d_data  out  32  digest word
- d_valid  out  1  digest word valid
- d_ready  in  1  digest word accepted when d_valid & d_ready
- d_last  out  1  high with 16th digest word
- busy  out  1  high unless in PACK with cnt==0 and no pending word

## Operation
- States: PACK, FLUSH, WAIT_DIGEST, DRAIN, CORE_RST. Reset -> PACK.
- Registers: wbuf[31:0], cnt[1:0] (bytes held), wfull (full word pending), lastseen, dreg[511:0], dcnt[3:0].
- PACK: s_ready = ~wfull & ~reset. An accepted byte is written to wbuf lane cnt (lane 0 = [31:24]); cnt increments mod 4.
  - 4th byte accepted: wfull<=1, cnt<=0; if s_last, lastseen<=1.
  - s_last on byte 1..3: go to FLUSH with cnt = bytes held; unused lanes zero.
  - wfull: k_in=wbuf, k_in_ready = ~k_buffer_full, k_is_last=0. On transfer, wfull<=0 and wbuf<=0; if lastseen, go to FLUSH with cnt=0.
- FLUSH: k_in_ready = k_is_last = ~k_buffer_full, k_byte_num=cnt, k_in=wbuf. On transfer go to WAIT_DIGEST and clear cnt, wbuf, and lastseen.
- WAIT_DIGEST: s_ready=0. When k_out_ready, dreg<=k_out, dcnt<=0, go to DRAIN.
- DRAIN: d_valid=1, d_data=dreg[511:480], d_last=(dcnt==15). On handshake, dreg<<=32 and dcnt++. A handshake with dcnt==15 goes to CORE_RST.
- CORE_RST: k_reset=1 for exactly one cycle, then PACK.
- k_in_ready and k_is_last are combinational from state and k_buffer_full. All other outputs come from registers.
- k_byte_num=0 whenever k_is_last=0.

## Timing
- Reset values:
  - s_ready=0 while reset is high and 1 the cycle after.
  - k_in=0, k_in_ready=0, k_is_last=0, k_byte_num=0, k_reset=1, d_valid=0, d_data=0, d_last=0, busy=0.
- 4th byte accepted in cycle N: k_in_ready can be high in N+1.
- s_last on a partial word in cycle N: k_is_last can be high in N+1.
- s_last on a 4th byte: word transfer at N+1 at the earliest, k_is_last (byte_num 0) at N+2 at the earliest.
- k_buffer_full high: transfer is held; k_in and k_byte_num are stable; the next byte is not accepted.
- k_out_ready seen in cycle M: d_valid=1 in M+1.
- 16th handshake in cycle P: k_reset=1 in P+1, s_ready=1 in P+2.
- d_ready low: d_data and d_last are held.
- Reset asserted mid-message or mid-drain: the next cycle is PACK with all registers cleared and the partial digest discarded. k_reset follows reset the same cycle.
- s_valid while s_ready=0 is ignored; nothing is dropped.

## Test plan
- "abc" (0x61,0x62,0x63, last on 0x63), buffer_full=0:
  - one transfer in the cycle after 0x63: k_in=0x61626300, k_is_last=1, k_byte_num=3.
- 4-byte 0x01..0x04, last on 0x04:
  - first transfer k_in=0x01020304, k_is_last=0;
  - next transfer k_is_last=1, k_byte_num=0.
- 9 bytes with k_buffer_full held high 5 cycles after the first word is pending:
  - k_in_ready stays 0 and s_ready stays 0 during the stall;
  - transfers are 2 full words, then is_last with byte_num=1 and k_in=0x09000000.
- Drive k_out = 512 bits of 0x00..0x3F bytes and pulse k_out_ready, with d_ready toggling 1/0:
  - words come out in order 0x00010203 … 0x3C3D3E3F;
  - d_last is set only on the 16th word;
  - k_reset pulses once, then s_ready=1.
- Reset asserted after 7 digest words:
  - d_valid=0 and busy=0 the next cycle;
  - a new "abc" message behaves exactly as in the first scenario.

Source files
------------

// File: rtl/keccak_msg_feeder.sv
// Byte-serial front end for the keccak core. It packs bytes big-endian into 32-bit words and feeds them to the core.
// After the core finishes, it streams out the 512-bit digest as sixteen words and resets the core.
module keccak_msg_feeder (
    input  logic         clk,
    input  logic         reset,
    input  logic [7:0]   s_data,
    input  logic         s_valid,
    input  logic         s_last,
    output logic         s_ready,
    output logic [31:0]  k_in,
    output logic         k_in_ready,
    output logic         k_is_last,
    output logic [1:0]   k_byte_num,
    input  logic         k_buffer_full,
    input  logic [511:0] k_out,
    input  logic         k_out_ready,
    output logic         k_reset,
    output logic [31:0]  d_data,
    output logic         d_valid,
    input  logic         d_ready,
    output logic         d_last,
    output logic         busy
);

    typedef enum logic [2:0] {
        PACK,
        FLUSH,
        WAIT_DIGEST,
        DRAIN,
        CORE_RST
    } state_t;

    state_t         state_q;
    logic [31:0]    wbuf_q;
    logic [31:0]    wbuf_d;
    logic [1:0]     cnt_q;
    logic           wfull_q;
    logic           lastseen_q;
    logic [511:0]   dreg_q;
    logic [3:0]     dcnt_q;
    logic           s_fire;
    logic           d_fire;

    assign s_ready    = (state_q == PACK) & ~wfull_q & ~reset;
    assign s_fire     = s_valid & s_ready;

    // Core handshake is combinational so a deasserted buffer_full is used in the same cycle.
    assign k_in_ready = ~reset & ~k_buffer_full &
                        (((state_q == PACK) & wfull_q) | (state_q == FLUSH));
    assign k_is_last  = ~reset & ~k_buffer_full & (state_q == FLUSH);
    assign k_byte_num = k_is_last ? cnt_q : 2'd0;
    assign k_in       = wbuf_q;
    assign k_reset    = reset | (state_q == CORE_RST);

    assign d_valid    = (state_q == DRAIN);
    assign d_data     = dreg_q[511:480];
    assign d_last     = d_valid & (dcnt_q == 4'd15);
    assign d_fire     = d_valid & d_ready;

    assign busy       = ~((state_q == PACK) & (cnt_q == 2'd0) & ~wfull_q);

    // Merge the incoming byte into its lane; lane 0 is the most significant byte.
    always_comb begin
        wbuf_d = wbuf_q;
        case (cnt_q)
            2'd0:    wbuf_d[31:24] = s_data;
            2'd1:    wbuf_d[23:16] = s_data;
            2'd2:    wbuf_d[15:8]  = s_data;
            default: wbuf_d[7:0]   = s_data;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= PACK;
            wbuf_q     <= '0;
            cnt_q      <= '0;
            wfull_q    <= 1'b0;
            lastseen_q <= 1'b0;
            dreg_q     <= '0;
            dcnt_q     <= '0;
        end else begin
            case (state_q)
                PACK: begin
                    if (wfull_q) begin
                        if (k_in_ready) begin
                            wfull_q <= 1'b0;
                            wbuf_q  <= '0;
                            if (lastseen_q) state_q <= FLUSH;
                        end
                    end else if (s_fire) begin
                        wbuf_q <= wbuf_d;
                        if (cnt_q == 2'd3) begin
                            wfull_q <= 1'b1;
                            cnt_q   <= '0;
                            if (s_last) lastseen_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 2'd1;
                            if (s_last) state_q <= FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    if (k_in_ready) begin
                        state_q    <= WAIT_DIGEST;
                        cnt_q      <= '0;
                        wbuf_q     <= '0;
                        lastseen_q <= 1'b0;
                    end
                end
                WAIT_DIGEST: begin
                    if (k_out_ready) begin
                        dreg_q  <= k_out;
                        dcnt_q  <= '0;
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (d_fire) begin
                        dreg_q <= {dreg_q[479:0], 32'd0};
                        dcnt_q <= dcnt_q + 4'd1;
                        if (dcnt_q == 4'd15) state_q <= CORE_RST;
                    end
                end
                CORE_RST: state_q <= PACK;
                default:  state_q <= PACK;
            endcase
        end
    end

endmodule

// File: tb/tb_keccak_msg_feeder.sv
// Directed bench for keccak_msg_feeder: covers packing, stalls, flushes, the digest drain and reset recovery.
module tb_keccak_msg_feeder;

    logic         clk;
    logic         reset;
    logic [7:0]   s_data;
    logic         s_valid;
    logic         s_last;
    logic         s_ready;
    logic [31:0]  k_in;
    logic         k_in_ready;
    logic         k_is_last;
    logic [1:0]   k_byte_num;
    logic         k_buffer_full;
    logic [511:0] k_out;
    logic         k_out_ready;
    logic         k_reset;
    logic [31:0]  d_data;
    logic         d_valid;
    logic         d_ready;
    logic         d_last;
    logic         busy;

    int n_checks = 0;
    int n_fails  = 0;
    int xfers    = 0;
    int lasts    = 0;

    keccak_msg_feeder dut (
        .clk(clk), .reset(reset),
        .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
        .k_in(k_in), .k_in_ready(k_in_ready), .k_is_last(k_is_last),
        .k_byte_num(k_byte_num), .k_buffer_full(k_buffer_full),
        .k_out(k_out), .k_out_ready(k_out_ready), .k_reset(k_reset),
        .d_data(d_data), .d_valid(d_valid), .d_ready(d_ready), .d_last(d_last),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!reset && k_in_ready) xfers++;
        if (!reset && k_in_ready && k_is_last) lasts++;
    end

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic l);
        int w;
        w = 0;
        s_valid = 1'b1;
        s_data  = b;
        s_last  = l;
        #1;
        while (!s_ready && w < 20) begin
            tick();
            w++;
        end
        chk("s_ready_wait", (w < 20), 1'b1);
        tick();
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic load_digest();
        for (int j = 0; j < 64; j++) k_out[511-8*j -: 8] = 8'(j);
        k_out_ready = 1'b1;
        tick();
        k_out_ready = 1'b0;
    endtask

    task automatic drain(input bit toggle, input int nwords);
        int i;
        int cyc;
        logic [31:0] exp;
        i = 0;
        cyc = 0;
        while (i < nwords && cyc < 100) begin
            d_ready = toggle ? ((cyc % 2) == 0) : 1'b1;
            #1;
            exp = {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)};
            chk("d_valid", d_valid, 1'b1);
            chk("d_data", d_data, exp);
            chk("d_last", d_last, (i == 15));
            if (d_ready) i++;
            tick();
            cyc++;
        end
        d_ready = 1'b0;
        chk("drain_done", (i == nwords), 1'b1);
    endtask

    task automatic abc_msg();
        int x0;
        int l0;
        x0 = xfers;
        l0 = lasts;
        send_byte(8'h61, 1'b0);
        send_byte(8'h62, 1'b0);
        send_byte(8'h63, 1'b1);
        #1;
        chk("abc_k_in_ready", k_in_ready, 1'b1);
        chk("abc_k_is_last", k_is_last, 1'b1);
        chk("abc_k_byte_num", k_byte_num, 2'd3);
        chk("abc_k_in", k_in, 32'h61626300);
        tick();
        chk("abc_after_k_in_ready", k_in_ready, 1'b0);
        chk("abc_after_s_ready", s_ready, 1'b0);
        chk("abc_busy", busy, 1'b1);
        chk("abc_xfers", xfers - x0, 1);
        chk("abc_lasts", lasts - l0, 1);
    endtask

    initial begin
        reset = 1'b1;
        s_data = '0; s_valid = 1'b0; s_last = 1'b0;
        k_buffer_full = 1'b0; k_out = '0; k_out_ready = 1'b0; d_ready = 1'b0;
        tick();
        tick();
        // Reset state
        chk("rst_s_ready", s_ready, 1'b0);
        chk("rst_k_reset", k_reset, 1'b1);
        chk("rst_k_in", k_in, 32'd0);
        chk("rst_k_in_ready", k_in_ready, 1'b0);
        chk("rst_k_is_last", k_is_last, 1'b0);
        chk("rst_k_byte_num", k_byte_num, 2'd0);
        chk("rst_d_valid", d_valid, 1'b0);
        chk("rst_d_data", d_data, 32'd0);
        chk("rst_d_last", d_last, 1'b0);
        chk("rst_busy", busy, 1'b0);
        reset = 1'b0;
        #1;
        chk("post_rst_s_ready", s_ready, 1'b1);
        chk("post_rst_k_reset", k_reset, 1'b0);

        // "abc" with digest drained at full rate
        abc_msg();
        load_digest();
        drain(1'b0, 16);
        #1;
        chk("cr1_k_reset", k_reset, 1'b1);
        chk("cr1_d_valid", d_valid, 1'b0);
        tick();
        chk("cr1_s_ready", s_ready, 1'b1);
        chk("cr1_k_reset_low", k_reset, 1'b0);

        // 4-byte message, last on 4th byte
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h03, 1'b0);
        send_byte(8'h04, 1'b1);
        #1;
        chk("w4_k_in_ready", k_in_ready, 1'b1);
        chk("w4_k_in", k_in, 32'h01020304);
        chk("w4_k_is_last", k_is_last, 1'b0);
        chk("w4_s_ready", s_ready, 1'b0);
        tick();
        chk("w4_last_ready", k_in_ready, 1'b1);
        chk("w4_last_is_last", k_is_last, 1'b1);
        chk("w4_last_byte_num", k_byte_num, 2'd0);
        chk("w4_last_k_in", k_in, 32'd0);
        tick();
        chk("w4_wait_k_in_ready", k_in_ready, 1'b0);

        // Digest drain with d_ready toggling
        load_digest();
        drain(1'b1, 16);
        #1;
        chk("cr2_k_reset", k_reset, 1'b1);
        tick();
        chk("cr2_k_reset_low", k_reset, 1'b0);
        chk("cr2_s_ready", s_ready, 1'b1);
        chk("cr2_busy", busy, 1'b0);

        // 9 bytes with buffer_full stall on the first word
        begin
            int x0;
            int l0;
            x0 = xfers;
            l0 = lasts;
            send_byte(8'h01, 1'b0);
            send_byte(8'h02, 1'b0);
            send_byte(8'h03, 1'b0);
            k_buffer_full = 1'b1;
            send_byte(8'h04, 1'b0);
            for (int c = 0; c < 5; c++) begin
                s_valid = 1'b1;
                s_data  = 8'h05;
                #1;
                chk("stall_k_in_ready", k_in_ready, 1'b0);
                chk("stall_s_ready", s_ready, 1'b0);
                chk("stall_k_in", k_in, 32'h01020304);
                tick();
            end
            s_valid = 1'b0;
            k_buffer_full = 1'b0;
            #1;
            chk("unstall_k_in_ready", k_in_ready, 1'b1);
            tick();
            send_byte(8'h05, 1'b0);
            send_byte(8'h06, 1'b0);
            send_byte(8'h07, 1'b0);
            send_byte(8'h08, 1'b0);
            #1;
            chk("w2_k_in", k_in, 32'h05060708);
            chk("w2_k_is_last", k_is_last, 1'b0);
            tick();
            send_byte(8'h09, 1'b1);
            #1;
            chk("w3_k_in", k_in, 32'h09000000);
            chk("w3_k_is_last", k_is_last, 1'b1);
            chk("w3_k_byte_num", k_byte_num, 2'd1);
            tick();
            chk("nine_xfers", xfers - x0, 3);
            chk("nine_lasts", lasts - l0, 1);
        end

        // Reset in the middle of the drain
        load_digest();
        drain(1'b0, 7);
        reset = 1'b1;
        #1;
        chk("mid_k_reset", k_reset, 1'b1);
        tick();
        reset = 1'b0;
        #1;
        chk("mid_d_valid", d_valid, 1'b0);
        chk("mid_busy", busy, 1'b0);
        chk("mid_s_ready", s_ready, 1'b1);
        chk("mid_d_data", d_data, 32'd0);
        abc_msg();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
